npcg_toggle_mnc_set_feature: RTL and testbench

- Toggle-NAND multi-NAND-command (MNC) engine that issues a SET FEATURES sequence: command EFh, one feature-address cycle, then a data-out burst.
- Write-direction counterpart of the read-ID MNC. It takes a command from the NPCG dispatcher and write beats from upstream.
- It drives the primitive-module (PM) bus: PBR, CAL, timer and DO primitives.
- It sits beside the other MNC blocks behind the PM arbiter.

---
 rtl/npcg_toggle_mnc_set_feature_if.sv | 52 +++++
 rtl/npcg_toggle_mnc_set_feature.sv | 138 +++++++++++++
 tb/tb_npcg_toggle_mnc_set_feature.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/npcg_toggle_mnc_set_feature_if.sv
// rtl/npcg_toggle_mnc_set_feature_if.sv - dispatcher, write-stream and PM bus bundle for the SET FEATURES MNC
interface npcg_toggle_mnc_set_feature_if #(
  parameter int NumberOfWays = 4
);
  logic [5:0]              iOpcode;
  logic [4:0]              iTargetID;
  logic [4:0]              iSourceID;
  logic [15:0]             iLength;
  logic                    iCMDValid;
  logic                    oCMDReady;
  logic [31:0]             iWriteData;
  logic                    iWriteLast;
  logic                    iWriteValid;
  logic                    oWriteReady;
  logic [NumberOfWays-1:0] iWaySelect;
  logic [15:0]             iColAddress;
  logic [23:0]             iRowAddress;
  logic                    oStart;
  logic                    oLastStep;
  logic [7:0]              iPM_Ready;
  logic [7:0]              iPM_LastStep;
  logic [7:0]              oPM_PCommand;
  logic [2:0]              oPM_PCommandOption;
  logic [NumberOfWays-1:0] oPM_TargetWay;
  logic [15:0]             oPM_NumOfData;
  logic                    oPM_CASelect;
  logic [7:0]              oPM_CAData;
  logic [31:0]             oPM_WriteData;
  logic                    oPM_WriteLast;
  logic                    oPM_WriteValid;
  logic                    iPM_WriteReady;

  modport slave (
    input  iOpcode, iTargetID, iSourceID, iLength, iCMDValid,
    input  iWriteData, iWriteLast, iWriteValid,
    input  iWaySelect, iColAddress, iRowAddress,
    input  iPM_Ready, iPM_LastStep, iPM_WriteReady,
    output oCMDReady, oWriteReady, oStart, oLastStep,
    output oPM_PCommand, oPM_PCommandOption, oPM_TargetWay, oPM_NumOfData,
    output oPM_CASelect, oPM_CAData, oPM_WriteData, oPM_WriteLast, oPM_WriteValid
  );

  modport master (
    output iOpcode, iTargetID, iSourceID, iLength, iCMDValid,
    output iWriteData, iWriteLast, iWriteValid,
    output iWaySelect, iColAddress, iRowAddress,
    output iPM_Ready, iPM_LastStep, iPM_WriteReady,
    input  oCMDReady, oWriteReady, oStart, oLastStep,
    input  oPM_PCommand, oPM_PCommandOption, oPM_TargetWay, oPM_NumOfData,
    input  oPM_CASelect, oPM_CAData, oPM_WriteData, oPM_WriteLast, oPM_WriteValid
  );
endinterface

// File: rtl/npcg_toggle_mnc_set_feature.sv
// rtl/npcg_toggle_mnc_set_feature.sv - Toggle-NAND SET FEATURES (EFh) MNC sequencer
// Optional NPCG_SETFT_LAST_GEN_EN: generate DO last from the beat counter and hold off surplus beats.
module npcg_toggle_mnc_set_feature #(
  parameter int NumberOfWays = 4
) (
  input logic                          iSystemClock,
  input logic                          iReset,
  npcg_toggle_mnc_set_feature_if.slave bus
);
  localparam logic [3:0] S_IDLE     = 4'd0;
  localparam logic [3:0] S_PBR      = 4'd1;
  localparam logic [3:0] S_CMDISSUE = 4'd2;
  localparam logic [3:0] S_CMDW0    = 4'd3;
  localparam logic [3:0] S_CMDW1    = 4'd4;
  localparam logic [3:0] S_TIMER1   = 4'd5;
  localparam logic [3:0] S_DOISSUE  = 4'd6;
  localparam logic [3:0] S_TIMER2   = 4'd7;
  localparam logic [3:0] S_WAITDONE = 4'd8;

  logic [3:0]              state_q, state_d;
  logic [NumberOfWays-1:0] way_q;
  logic [15:0]             len_q, col_q, cnt_q, cnt_d;
  logic [23:0]             row_q;
  logic [4:0]              src_q;
  logic                    trig, accept, wr_valid, wr_ready, beat;

  assign trig   = bus.iCMDValid & (bus.iTargetID == 5'b00101) & (bus.iOpcode == 6'b101101);
  assign accept = trig & (state_q == S_IDLE);

  assign bus.oStart        = trig;
  assign bus.oCMDReady     = (state_q == S_IDLE);
  assign bus.oPM_TargetWay = way_q;
  assign bus.oPM_WriteData = bus.iWriteData;
  assign bus.oWriteReady   = wr_ready;
  assign bus.oPM_WriteValid = wr_valid;
  assign beat = wr_valid & bus.iPM_WriteReady;

`ifdef NPCG_SETFT_LAST_GEN_EN
  logic open_w;
  assign open_w            = (cnt_q < len_q);
  assign wr_valid          = bus.iWriteValid & open_w;
  assign wr_ready          = bus.iPM_WriteReady & open_w;
  assign bus.oPM_WriteLast = wr_valid & (cnt_q == len_q - 16'd1);
  logic unused_last;
  assign unused_last = bus.iWriteLast;
`else
  assign wr_valid          = bus.iWriteValid;
  assign wr_ready          = bus.iPM_WriteReady;
  assign bus.oPM_WriteLast = bus.iWriteLast;
`endif

  logic unused_bits;
  assign unused_bits = ^{row_q, src_q, col_q[15:8], bus.iPM_Ready[7], bus.iPM_LastStep[7],
                         bus.iPM_LastStep[5:4], bus.iPM_LastStep[1]};

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:     if (trig) state_d = S_PBR;
      S_PBR:      if (bus.iPM_Ready[6:0] == 7'h7F) state_d = S_CMDISSUE;
      S_CMDISSUE: if (bus.iPM_LastStep[6]) state_d = S_CMDW0;
      S_CMDW0:    state_d = S_CMDW1;
      S_CMDW1:    state_d = S_TIMER1;
      S_TIMER1:   if (bus.iPM_LastStep[3]) state_d = S_DOISSUE;
      S_DOISSUE:  if (bus.iPM_LastStep[0]) state_d = S_TIMER2;
      S_TIMER2:   if (bus.iPM_LastStep[2]) state_d = S_WAITDONE;
      S_WAITDONE: if (bus.iPM_LastStep[0]) state_d = S_IDLE;
      default:    state_d = S_IDLE;
    endcase
  end

  // Everything the PM sees is decoded from state so an async reset clears it at once.
  always_comb begin
    bus.oPM_PCommand       = 8'h00;
    bus.oPM_PCommandOption = 3'b000;
    bus.oPM_NumOfData      = 16'd0;
    bus.oPM_CASelect       = 1'b0;
    bus.oPM_CAData         = 8'h00;
    bus.oLastStep          = 1'b0;
    case (state_q)
      S_PBR:      bus.oPM_PCommand = 8'h40;
      S_CMDISSUE: begin
        bus.oPM_PCommand  = 8'h08;
        bus.oPM_NumOfData = 16'd1;
      end
      S_CMDW0:    bus.oPM_CAData = 8'hEF;
      S_CMDW1:    begin
        bus.oPM_CASelect = 1'b1;
        bus.oPM_CAData   = col_q[7:0];
      end
      S_TIMER1:   begin
        bus.oPM_PCommand       = 8'h01;
        bus.oPM_PCommandOption = 3'b001;
        bus.oPM_NumOfData      = 16'd29;
      end
      S_DOISSUE:  begin
        bus.oPM_PCommand       = 8'h04;
        bus.oPM_PCommandOption = 3'b001;
        bus.oPM_NumOfData      = len_q;
      end
      S_TIMER2:   begin
        bus.oPM_PCommand       = 8'h01;
        bus.oPM_PCommandOption = 3'b100;
        bus.oPM_NumOfData      = 16'd9;
      end
      S_WAITDONE: bus.oLastStep = bus.iPM_LastStep[0];
      default:    ;
    endcase
  end

  always_comb begin
    cnt_d = cnt_q;
    if (accept) cnt_d = 16'd0;
    else if (beat && (cnt_q != len_q)) cnt_d = cnt_q + 16'd1;
  end

  always_ff @(posedge iSystemClock or posedge iReset) begin
    if (iReset) begin
      state_q <= S_IDLE;
      way_q   <= '0;
      len_q   <= 16'd0;
      col_q   <= 16'd0;
      row_q   <= 24'd0;
      src_q   <= 5'd0;
      cnt_q   <= 16'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        way_q <= bus.iWaySelect;
        len_q <= (bus.iLength == 16'd0) ? 16'd1 : bus.iLength;
        col_q <= bus.iColAddress;
        row_q <= bus.iRowAddress;
        src_q <= bus.iSourceID;
      end
    end
  end
endmodule

// File: tb/tb_npcg_toggle_mnc_set_feature.sv
// tb/tb_npcg_toggle_mnc_set_feature.sv - directed vector bench for the SET FEATURES MNC
module tb_npcg_toggle_mnc_set_feature;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  npcg_toggle_mnc_set_feature_if #(.NumberOfWays(4)) bus ();
  npcg_toggle_mnc_set_feature #(.NumberOfWays(4)) dut (
    .iSystemClock(clk),
    .iReset      (rst),
    .bus         (bus.slave)
  );

  typedef struct {
    logic       valid;
    logic [4:0] target;
    logic [5:0] opcode;
    logic       exp_start;
  } trig_vec_t;

  int vectors = 0;
  int miscompares = 0;
  logic [31:0] beats[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input logic [7:0] v);
    bus.iPM_LastStep = v;
    tick();
    bus.iPM_LastStep = 8'h00;
    #1;
  endtask

  task automatic do_seq(input logic [3:0] way, input logic [15:0] col, input logic [15:0] len,
                        input bit inject, input bit rst_mid);
    logic [15:0] len_eff;
    int n;
    len_eff = (len == 16'd0) ? 16'd1 : len;
    bus.iWaySelect = way; bus.iColAddress = col; bus.iLength = len;
    bus.iOpcode = 6'b101101; bus.iTargetID = 5'b00101; bus.iCMDValid = 1'b1;
    bus.iRowAddress = 24'h123456; bus.iSourceID = 5'h03;
    #1;
    chk("trig_start", {31'd0, bus.oStart}, 32'd1);
    chk("trig_ready", {31'd0, bus.oCMDReady}, 32'd1);
    tick();
    bus.iCMDValid = 1'b0;
    #1;
    chk("pbr_pcmd", {24'd0, bus.oPM_PCommand}, 32'h40);
    chk("pbr_cmdready", {31'd0, bus.oCMDReady}, 32'd0);
    chk("target_way", {28'd0, bus.oPM_TargetWay}, {28'd0, way});
    bus.iPM_Ready = 8'h3F;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("pbr_hold", {24'd0, bus.oPM_PCommand}, 32'h40);
    end
    bus.iPM_Ready = 8'h7F;
    tick();
    chk("cmdissue_pcmd", {24'd0, bus.oPM_PCommand}, 32'h08);
    chk("cmdissue_num", {16'd0, bus.oPM_NumOfData}, 32'd1);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("cmdissue_wait", {24'd0, bus.oPM_PCommand}, 32'h08);
    end
    pulse(8'h45);
    chk("cmdw0_pcmd", {24'd0, bus.oPM_PCommand}, 32'h00);
    chk("cmdw0_casel", {31'd0, bus.oPM_CASelect}, 32'd0);
    chk("cmdw0_cadata", {24'd0, bus.oPM_CAData}, 32'hEF);
    tick();
    chk("cmdw1_casel", {31'd0, bus.oPM_CASelect}, 32'd1);
    chk("cmdw1_cadata", {24'd0, bus.oPM_CAData}, {24'd0, col[7:0]});
    tick();
    chk("timer1_pcmd", {24'd0, bus.oPM_PCommand}, 32'h01);
    chk("timer1_opt", {29'd0, bus.oPM_PCommandOption}, 32'd1);
    chk("timer1_num", {16'd0, bus.oPM_NumOfData}, 32'd29);
    pulse(8'h45);
    chk("timer1_other_bits", {24'd0, bus.oPM_PCommand}, 32'h01);
    pulse(8'h08);
    chk("doissue_pcmd", {24'd0, bus.oPM_PCommand}, 32'h04);
    chk("doissue_opt", {29'd0, bus.oPM_PCommandOption}, 32'd1);
    chk("doissue_num", {16'd0, bus.oPM_NumOfData}, {16'd0, len_eff});
    if (rst_mid) begin
      #1 rst = 1'b1;
      #1;
      chk("rst_pcmd", {24'd0, bus.oPM_PCommand}, 32'h00);
      chk("rst_num", {16'd0, bus.oPM_NumOfData}, 32'd0);
      chk("rst_opt", {29'd0, bus.oPM_PCommandOption}, 32'd0);
      chk("rst_way", {28'd0, bus.oPM_TargetWay}, 32'd0);
      chk("rst_cmdready", {31'd0, bus.oCMDReady}, 32'd1);
      tick();
      rst = 1'b0;
      tick();
      return;
    end
    if (inject) begin
      bus.iWaySelect = 4'b1000;
      bus.iCMDValid = 1'b1;
      #1;
      chk("inject_start", {31'd0, bus.oStart}, 32'd1);
      chk("inject_cmdready", {31'd0, bus.oCMDReady}, 32'd0);
      tick();
      bus.iCMDValid = 1'b0;
      bus.iWaySelect = way;
      chk("inject_pcmd", {24'd0, bus.oPM_PCommand}, 32'h04);
      chk("inject_way", {28'd0, bus.oPM_TargetWay}, {28'd0, way});
    end
    n = beats.size();
    for (int i = 0; i < n; i++) begin
      logic rdy;
      int tries;
      bit done;
      tries = 0;
      done = 0;
      bus.iWriteData = beats[i];
      bus.iWriteValid = 1'b1;
      bus.iWriteLast = (i == n - 1);
      while (!done) begin
        rdy = (tries >= 4) ? 1'b1 : 1'($urandom_range(0, 1));
        bus.iPM_WriteReady = rdy;
        #1;
        chk("beat_data", bus.oPM_WriteData, beats[i]);
        chk("beat_valid", {31'd0, bus.oPM_WriteValid}, 32'd1);
        chk("beat_ready", {31'd0, bus.oWriteReady}, {31'd0, rdy});
        chk("beat_last", {31'd0, bus.oPM_WriteLast}, {31'd0, i == n - 1});
        tick();
        done = rdy;
        tries++;
      end
    end
    bus.iWriteValid = 1'b0; bus.iWriteLast = 1'b0; bus.iPM_WriteReady = 1'b0;
`ifdef NPCG_SETFT_LAST_GEN_EN
    bus.iWriteValid = 1'b1; bus.iWriteLast = 1'b1; bus.iPM_WriteReady = 1'b1;
    #1;
    chk("surplus_valid", {31'd0, bus.oPM_WriteValid}, 32'd0);
    chk("surplus_ready", {31'd0, bus.oWriteReady}, 32'd0);
    chk("surplus_last", {31'd0, bus.oPM_WriteLast}, 32'd0);
    bus.iWriteValid = 1'b0; bus.iWriteLast = 1'b0; bus.iPM_WriteReady = 1'b0;
`endif
    pulse(8'h01);
    chk("timer2_pcmd", {24'd0, bus.oPM_PCommand}, 32'h01);
    chk("timer2_opt", {29'd0, bus.oPM_PCommandOption}, 32'd4);
    chk("timer2_num", {16'd0, bus.oPM_NumOfData}, 32'd9);
    pulse(8'h04);
    chk("waitdone_pcmd", {24'd0, bus.oPM_PCommand}, 32'h00);
    chk("waitdone_laststep_lo", {31'd0, bus.oLastStep}, 32'd0);
    bus.iPM_LastStep = 8'h01;
    #1;
    chk("waitdone_laststep_hi", {31'd0, bus.oLastStep}, 32'd1);
    tick();
    bus.iPM_LastStep = 8'h00;
    #1;
    chk("done_cmdready", {31'd0, bus.oCMDReady}, 32'd1);
    chk("done_laststep", {31'd0, bus.oLastStep}, 32'd0);
  endtask

  initial begin
    trig_vec_t tv[6];
    tv[0] = '{1'b1, 5'b00101, 6'b101101, 1'b1};
    tv[1] = '{1'b0, 5'b00101, 6'b101101, 1'b0};
    tv[2] = '{1'b1, 5'b00101, 6'b101011, 1'b0};
    tv[3] = '{1'b1, 5'b00100, 6'b101101, 1'b0};
    tv[4] = '{1'b1, 5'b10101, 6'b101100, 1'b0};
    tv[5] = '{1'b0, 5'b00000, 6'b000000, 1'b0};

    bus.iOpcode = '0; bus.iTargetID = '0; bus.iSourceID = '0; bus.iLength = '0;
    bus.iCMDValid = 1'b0; bus.iWriteData = '0; bus.iWriteLast = 1'b0; bus.iWriteValid = 1'b0;
    bus.iWaySelect = '0; bus.iColAddress = '0; bus.iRowAddress = '0;
    bus.iPM_Ready = 8'h00; bus.iPM_LastStep = 8'h00; bus.iPM_WriteReady = 1'b0;

    #2;
    chk("reset_cmdready", {31'd0, bus.oCMDReady}, 32'd1);
    chk("reset_pcmd", {24'd0, bus.oPM_PCommand}, 32'h00);
    chk("reset_way", {28'd0, bus.oPM_TargetWay}, 32'd0);
    chk("reset_laststep", {31'd0, bus.oLastStep}, 32'd0);
    tick();
    rst = 1'b0;
    tick();

    for (int i = 0; i < 6; i++) begin
      bus.iCMDValid = tv[i].valid; bus.iTargetID = tv[i].target; bus.iOpcode = tv[i].opcode;
      #1;
      chk("table_start", {31'd0, bus.oStart}, {31'd0, tv[i].exp_start});
      bus.iCMDValid = 1'b0;
      tick();
      chk("table_idle", {31'd0, bus.oCMDReady}, 32'd1);
    end

    beats = '{32'h000000AA};
    do_seq(4'b0010, 16'h0001, 16'd1, 1'b0, 1'b0);
    beats = '{32'h000000AA, 32'h000000BB, 32'h000000CC, 32'h000000DD};
    do_seq(4'b0100, 16'h00A5, 16'd4, 1'b1, 1'b0);
    do_seq(4'b0001, 16'h0010, 16'd4, 1'b0, 1'b1);
    beats = '{32'h12345678};
    do_seq(4'b1000, 16'h0002, 16'd0, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end
endmodule
